rs232_tx_arb: RTL and testbench

RS232_TX_ARB -- requirements
Module: rs232_tx_arb

---
 rtl/rs232_tx_arb.sv | 202 ++++++++++++++++++++
 tb/tb_rs232_tx_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_arb.sv
// rs232_tx_arb
//   Shares one RS-232 serializer between four upstream byte FIFOs.
//   Channels are granted round-robin. Each grant sends one burst of at most
//   P_BURST_MAX data bytes, then the search restarts at the channel after
//   the one just served.
//
//   Optional feature macro: RS232_ARB_HDR_EN
//     defined   - each burst is preceded by a header byte {4'hA, 2'b00, gnt}
//     undefined - bursts carry data bytes only (default build)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   up_data    four upstream read-data buses, channel i on [8i+7:8i],
//              valid the cycle after the matching up_rd_en bit
//   up_empty   upstream empty flags, one per channel
//   up_rd_en   upstream read strobes, one-cycle pulses
//   out_data   byte offered to the serializer
//   out_empty  low while out_data holds a byte the serializer has not taken
//   out_rd_en  serializer read strobe
//   ser_done   serializer pulse at the end of the stop bit
//   gnt        currently granted channel
//   busy       high whenever the arbiter is not idle

module rs232_tx_arb #(
  parameter int unsigned P_BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] up_data,
  input  logic [3:0]  up_empty,
  output logic [3:0]  up_rd_en,
  output logic [7:0]  out_data,
  output logic        out_empty,
  input  logic        out_rd_en,
  input  logic        ser_done,
  output logic [1:0]  gnt,
  output logic        busy
);

  localparam logic [7:0] BURST_MAX_C = 8'(P_BURST_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
`ifdef RS232_ARB_HDR_EN
    S_HDR  = 3'd1,
`endif
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t      state_r,     state_s;
  logic [1:0]  gnt_r,       gnt_s;
  logic [1:0]  rr_ptr_r,    rr_ptr_s;
  logic [7:0]  burst_cnt_r, burst_cnt_s;
  logic [7:0]  out_data_r,  out_data_s;
  logic        out_vld_r,   out_vld_s;
  logic        in_flight_r, in_flight_s;
  logic [3:0]  up_rd_en_r,  up_rd_en_s;

  logic        pick_vld_s;
  logic [1:0]  pick_s;
  logic [1:0]  cand_s;
  logic        out_empty_s;

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    ch_onehot = 4'b0001 << ch;
  endfunction

  // The byte is "offered" only while loaded and not yet taken.
  assign out_empty_s = ~(out_vld_r & ~in_flight_r);

  assign up_rd_en  = up_rd_en_r;
  assign out_data  = out_data_r;
  assign out_empty = out_empty_s;
  assign gnt       = gnt_r;
  assign busy      = (state_r != S_IDLE);

  // Round-robin search: first non-empty channel starting at rr_ptr.
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = rr_ptr_r;
    cand_s     = rr_ptr_r;
    for (int k = 3; k >= 0; k--) begin
      cand_s = rr_ptr_r + 2'(k);
      if (!up_empty[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = cand_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Next-state and datapath decode for the burst FSM.
  // The read strobe is registered on the transition into S_RD, so it is
  // only raised after up_empty of the target channel was seen low; an
  // upstream FIFO can only become empty through our own reads.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    out_data_s  = out_data_r;
    out_vld_s   = out_vld_r;
    in_flight_s = in_flight_r;
    up_rd_en_s  = 4'b0000;

    // Serializer takes the offered byte; strobes while nothing is offered
    // are ignored.
    if (out_rd_en && !out_empty_s) begin
      in_flight_s = 1'b1;
    end else begin
      in_flight_s = in_flight_r;
    end

    case (state_r)
      S_IDLE: begin
        if (pick_vld_s) begin
          gnt_s       = pick_s;
          burst_cnt_s = 8'd0;
`ifdef RS232_ARB_HDR_EN
          state_s     = S_HDR;
`else
          state_s     = S_RD;
          up_rd_en_s  = ch_onehot(pick_s);
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
`ifdef RS232_ARB_HDR_EN
      S_HDR: begin
        out_data_s = {4'hA, 2'b00, gnt_r};
        out_vld_s  = 1'b1;
        state_s    = S_WAIT;
      end
`endif
      S_RD: begin
        // Saturate rather than wrap; P_BURST_MAX never exceeds 255.
        if (burst_cnt_r != 8'hFF) begin
          burst_cnt_s = burst_cnt_r + 8'd1;
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
        state_s = S_CAP;
      end
      S_CAP: begin
        out_data_s = up_data[{gnt_r, 3'b000} +: 8];
        out_vld_s  = 1'b1;
        state_s    = S_WAIT;
      end
      S_WAIT: begin
        // Only the end of a byte we actually handed over counts.
        if (ser_done && in_flight_r) begin
          out_vld_s   = 1'b0;
          in_flight_s = 1'b0;
          if ((burst_cnt_r < BURST_MAX_C) && !up_empty[gnt_r]) begin
            state_s    = S_RD;
            up_rd_en_s = ch_onehot(gnt_r);
          end else begin
            state_s  = S_IDLE;
            rr_ptr_s = gnt_r + 2'd1;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      default: begin
        state_s     = S_IDLE;
        out_vld_s   = 1'b0;
        in_flight_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any byte in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      gnt_r       <= 2'd0;
      rr_ptr_r    <= 2'd0;
      burst_cnt_r <= 8'd0;
      out_data_r  <= 8'h00;
      out_vld_r   <= 1'b0;
      in_flight_r <= 1'b0;
      up_rd_en_r  <= 4'b0000;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
      out_data_r  <= out_data_s;
      out_vld_r   <= out_vld_s;
      in_flight_r <= in_flight_s;
      up_rd_en_r  <= up_rd_en_s;
    end
  end

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Bench for rs232_tx_arb. Two instances: dut0 with P_BURST_MAX=16 and
// dut1 with P_BURST_MAX=2. Each has an upstream FIFO model, a serializer
// model and a monitor that pops expected {gnt, byte} pairs from a
// scoreboard queue whenever the serializer takes a byte.
module tb_rs232_tx_arb;

  logic             clk;
  logic             rst_n;
  logic [1:0][31:0] up_data;
  logic [1:0][3:0]  up_empty;
  logic [1:0][3:0]  up_rd_en;
  logic [1:0][7:0]  out_data;
  logic [1:0]       out_empty;
  logic [1:0]       out_rd_en;
  logic [1:0]       ser_done;
  logic [1:0][1:0]  gnt;
  logic [1:0]       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int grants [2];

  logic [7:0] fq    [2][4][$];
  logic [9:0] exp_q [2][$];

  rs232_tx_arb #(.P_BURST_MAX(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .up_data(up_data[0]), .up_empty(up_empty[0]),
    .up_rd_en(up_rd_en[0]), .out_data(out_data[0]), .out_empty(out_empty[0]),
    .out_rd_en(out_rd_en[0]), .ser_done(ser_done[0]), .gnt(gnt[0]), .busy(busy[0])
  );

  rs232_tx_arb #(.P_BURST_MAX(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .up_data(up_data[1]), .up_empty(up_empty[1]),
    .up_rd_en(up_rd_en[1]), .out_data(out_data[1]), .out_empty(out_empty[1]),
    .out_rd_en(out_rd_en[1]), .ser_done(ser_done[1]), .gnt(gnt[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [1:0] g, input logic [7:0] b);
    exp_q[d].push_back({g, b});
  endtask

  task automatic push_hdr(input int d, input logic [1:0] g);
`ifdef RS232_ARB_HDR_EN
    push_exp(d, g, {4'hA, 2'b00, g});
`endif
  endtask

  task automatic load(input int d, input int c, input logic [7:0] b);
    fq[d][c].push_back(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until all expected bytes were delivered and the DUT is idle again.
  task automatic drain(input int d, input string nm);
    int n;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while ((exp_q[d].size() != 0 || busy[d]) && n < 600);
    cyc(3);
    chk({nm, " drained"}, 32'({exp_q[d].size() != 0, busy[d]}), 32'd0);
  endtask

  for (genvar gd = 0; gd < 2; gd++) begin : g_env
    logic [3:0] rd_seen;
    logic [9:0] e;
    logic [7:0] held;
    logic       holding, hold_bad;
    logic       empty_prev, busy_prev, rd_h1, rd_h2, sd_h1, br_h1, rd_now, br_now;

    // Upstream FIFO model: data appears the cycle after the read strobe.
    initial begin
      up_data[gd]  = 32'h0;
      up_empty[gd] = 4'hF;
      forever begin
        @(negedge clk);
        rd_seen = up_rd_en[gd];
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
          if (rd_seen[c]) begin
            if (fq[gd][c].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL d%0d underflow: read strobe on empty ch%0d", gd, c);
            end else begin
              up_data[gd][8*c +: 8] = fq[gd][c].pop_front();
            end
          end
          up_empty[gd][c] = (fq[gd][c].size() == 0);
        end
      end
    end

    // Serializer model: take an offered byte, send it, pulse ser_done.
    initial begin
      out_rd_en[gd] = 1'b0;
      ser_done[gd]  = 1'b0;
      forever begin
        cyc(1);
        if (!out_empty[gd]) begin
          out_rd_en[gd] = 1'b1;
          cyc(1);
          out_rd_en[gd] = 1'b0;
          cyc(3);
          ser_done[gd] = 1'b1;
          cyc(1);
          ser_done[gd] = 1'b0;
        end
      end
    end

    // Monitor: scoreboard pop on each take, plus strobe legality and latency.
    initial begin
      grants[gd] = 0;
      holding = 1'b0; hold_bad = 1'b0; held = 8'h00;
      empty_prev = 1'b1; busy_prev = 1'b0;
      rd_h1 = 1'b0; rd_h2 = 1'b0; sd_h1 = 1'b0; br_h1 = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          holding = 1'b0; empty_prev = 1'b1; busy_prev = 1'b0;
          rd_h1 = 1'b0; rd_h2 = 1'b0; sd_h1 = 1'b0; br_h1 = 1'b0;
        end else begin
          rd_now = |up_rd_en[gd];
          br_now = busy[gd] && !busy_prev;
          if (br_now) grants[gd]++;

          if (out_rd_en[gd] && !out_empty[gd]) begin
            if (exp_q[gd].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL d%0d take: got %h, no byte required", gd, {gnt[gd], out_data[gd]});
            end else begin
              e = exp_q[gd].pop_front();
              chk($sformatf("d%0d take {gnt,byte}", gd), 32'({gnt[gd], out_data[gd]}), 32'(e));
            end
            held = out_data[gd];
            holding = 1'b1;
            hold_bad = 1'b0;
          end else if (holding) begin
            if (out_data[gd] != held) hold_bad = 1'b1;
            if (ser_done[gd]) begin
              chk($sformatf("d%0d out_data hold", gd), 32'(hold_bad), 32'd0);
              holding = 1'b0;
            end
          end

          for (int c = 0; c < 4; c++) begin
            if (up_rd_en[gd][c]) begin
              chk($sformatf("d%0d rd legal ch%0d", gd, c),
                  32'({up_empty[gd][c], gnt[gd] != 2'(c)}), 32'd0);
            end
          end

          // Read strobe follows ser_done by one cycle (or the grant itself
          // when there is no header).
          if (rd_now && !rd_h1) begin
`ifdef RS232_ARB_HDR_EN
            chk($sformatf("d%0d rd latency", gd), 32'(sd_h1), 32'd1);
`else
            chk($sformatf("d%0d rd latency", gd), 32'(sd_h1 || br_now), 32'd1);
`endif
          end

          // Byte offered two cycles after its read strobe (the cycle after
          // capture), or one cycle after the header state.
          if (!out_empty[gd] && empty_prev) begin
`ifdef RS232_ARB_HDR_EN
            chk($sformatf("d%0d out latency", gd), 32'(rd_h2 || br_h1), 32'd1);
`else
            chk($sformatf("d%0d out latency", gd), 32'(rd_h2), 32'd1);
`endif
          end

          rd_h2 = rd_h1; rd_h1 = rd_now;
          sd_h1 = ser_done[gd];
          br_h1 = br_now;
          busy_prev = busy[gd];
          empty_prev = out_empty[gd];
        end
      end
    end
  end

  initial begin
    int base, n;
    rst_n = 1'b0;
    cyc(3);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset out_empty", d), 32'(out_empty[d]), 32'd1);
      chk($sformatf("d%0d reset up_rd_en", d),  32'(up_rd_en[d]),  32'd0);
      chk($sformatf("d%0d reset busy", d),      32'(busy[d]),      32'd0);
      chk($sformatf("d%0d reset gnt", d),       32'(gnt[d]),       32'd0);
      chk($sformatf("d%0d reset out_data", d),  32'(out_data[d]),  32'd0);
    end
    rst_n = 1'b1;
    cyc(2);

    // Ch2 holds 11,22,33 alone.
    base = grants[0];
    push_hdr(0, 2'd2);
    push_exp(0, 2'd2, 8'h11); push_exp(0, 2'd2, 8'h22); push_exp(0, 2'd2, 8'h33);
    load(0, 2, 8'h11); load(0, 2, 8'h22); load(0, 2, 8'h33);
    drain(0, "ch2 burst");
    chk("ch2 burst grants", 32'(grants[0] - base), 32'd1);

    // rr_ptr now 3: with ch1 and ch3 both pending, ch3 goes first.
    base = grants[0];
    push_hdr(0, 2'd3); push_exp(0, 2'd3, 8'h55);
    push_hdr(0, 2'd1); push_exp(0, 2'd1, 8'h44);
    load(0, 1, 8'h44); load(0, 3, 8'h55);
    drain(0, "rr after ch2");
    chk("rr after ch2 grants", 32'(grants[0] - base), 32'd2);

    // Ch1 holds 20 bytes with burst limit 16: 16, back to idle, then 4.
    base = grants[0];
    push_hdr(0, 2'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 16) push_hdr(0, 2'd1);
      push_exp(0, 2'd1, 8'h60 + 8'(i));
      load(0, 1, 8'h60 + 8'(i));
    end
    drain(0, "ch1 20 bytes");
    chk("ch1 20 bytes grants", 32'(grants[0] - base), 32'd2);

    // Ch0 empties after one byte: no further read, back to idle.
    base = grants[0];
    push_hdr(0, 2'd0); push_exp(0, 2'd0, 8'h77);
    load(0, 0, 8'h77);
    drain(0, "ch0 single");
    chk("ch0 single grants", 32'(grants[0] - base), 32'd1);

    // All four channels hold 3 bytes, burst limit 2: 0,1,2,3 x2 then x1.
    base = grants[1];
    for (int c = 0; c < 4; c++) begin
      push_hdr(1, 2'(c));
      push_exp(1, 2'(c), 8'h10 * 8'(c + 1));
      push_exp(1, 2'(c), 8'h10 * 8'(c + 1) + 8'h01);
    end
    for (int c = 0; c < 4; c++) begin
      push_hdr(1, 2'(c));
      push_exp(1, 2'(c), 8'h10 * 8'(c + 1) + 8'h02);
    end
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++)
        load(1, c, 8'h10 * 8'(c + 1) + 8'(i));
    drain(1, "four ch rr");
    chk("four ch rr grants", 32'(grants[1] - base), 32'd8);

    // Ch3 holds a single 5A.
    base = grants[1];
    push_hdr(1, 2'd3); push_exp(1, 2'd3, 8'h5A);
    load(1, 3, 8'h5A);
    drain(1, "ch3 5A");
    chk("ch3 5A grants", 32'(grants[1] - base), 32'd1);

    // Reset while a byte of a ch1 burst is in flight.
    push_hdr(0, 2'd1);
    push_exp(0, 2'd1, 8'h81); push_exp(0, 2'd1, 8'h82); push_exp(0, 2'd1, 8'h83);
    load(0, 1, 8'h81); load(0, 1, 8'h82); load(0, 1, 8'h83);
    base = exp_q[0].size();
    n = 0;
    while (exp_q[0].size() == base && n < 100) begin
      cyc(1);
      n++;
    end
    chk("reset burst first take", 32'(exp_q[0].size() < base), 32'd1);
    chk("reset burst in wait", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_empty", 32'(out_empty[0]), 32'd1);
    chk("mid reset up_rd_en",  32'(up_rd_en[0]),  32'd0);
    chk("mid reset busy",      32'(busy[0]),      32'd0);
    exp_q[0].delete();
    for (int c = 0; c < 4; c++) fq[0][c].delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(10);

    // After reset arbitration restarts at ch0.
    base = grants[0];
    push_hdr(0, 2'd0); push_exp(0, 2'd0, 8'h90);
    push_hdr(0, 2'd2); push_exp(0, 2'd2, 8'h92);
    load(0, 0, 8'h90); load(0, 2, 8'h92);
    drain(0, "post reset");
    chk("post reset grants", 32'(grants[0] - base), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
